// File: rtl/stage_memory_pkg.sv
// Shared CPU defines: ALU command codes, memory-op codes, memory-stage FSM states.
package stage_memory_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LB   = 3'd2,
    MEM_LBU  = 3'd3,
    MEM_SW   = 3'd4,
    MEM_SB   = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OUT  = 2'd2
  } mem_state_e;

  // Unused encodings (6, 7) behave as NONE.
  function automatic mem_op_e decode_mem_op(input logic [2:0] code);
    case (code)
      3'd1:    return MEM_LW;
      3'd2:    return MEM_LB;
      3'd3:    return MEM_LBU;
      3'd4:    return MEM_SW;
      3'd5:    return MEM_SB;
      default: return MEM_NONE;
    endcase
  endfunction

  // Word accesses need a word-aligned address; byte accesses never fault.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    return ((op == MEM_LW) || (op == MEM_SW)) && (lo != 2'b00);
  endfunction

  function automatic logic is_load_op(input mem_op_e op);
    return (op == MEM_LW) || (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic is_store_op(input mem_op_e op);
    return (op == MEM_SW) || (op == MEM_SB);
  endfunction

endpackage

// File: rtl/stage_memory_if.sv
// Execute-in, memory-bus and writeback-out signals of the memory stage.
interface stage_memory_if;
  logic        exValid;
  logic        exReady;
  logic [31:0] exAluResult;
  logic [31:0] exStoreData;
  logic [4:0]  exRegDest;
  logic [2:0]  exMemOp;

  logic        memReq;
  logic        memWe;
  logic [31:2] memWordAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRData;

  logic        wbValid;
  logic        wbReady;
  logic [4:0]  wbRegDest;
  logic [31:0] wbData;
  logic        wbWriteEnable;
  logic        wbErr;

  // Stage side.
  modport slave (
    input  exValid, exAluResult, exStoreData, exRegDest, exMemOp,
    input  memAck, memRData, wbReady,
    output exReady, memReq, memWe, memWordAddr, memWData, memByteEn,
    output wbValid, wbRegDest, wbData, wbWriteEnable, wbErr
  );

  // Environment side (execute stage, memory, writeback).
  modport master (
    output exValid, exAluResult, exStoreData, exRegDest, exMemOp,
    output memAck, memRData, wbReady,
    input  exReady, memReq, memWe, memWordAddr, memWData, memByteEn,
    input  wbValid, wbRegDest, wbData, wbWriteEnable, wbErr
  );
endinterface

// File: rtl/stage_memory_load_align.sv
// Load extraction: pick one byte lane of a read word and sign/zero extend it.
module load_align (
  input  logic [31:0] word,
  input  logic [1:0]  byte_sel,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0] sel_byte;

  // Lane 0 is bits 7:0; extend with bit 7 only for signed loads.
  always_comb begin
    sel_byte = '0;
    case (byte_sel)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = '0;
    endcase
    data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
  end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: issues loads/stores, aligns load data, times out
// unanswered requests and hands one result at a time to writeback.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  stage_memory_if.slave  bus
);

  // Counter value in the last REQ cycle before the timeout fires.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_op_e     op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_err_q, wb_err_d;

  mem_op_e     in_op;
  logic        in_misal;
  logic        ex_ready;
  logic        accept;
  mem_state_e  accept_target;
  logic        timeout_hit;
  logic [31:0] load_byte;

  assign in_op       = decode_mem_op(bus.exMemOp);
  assign in_misal    = is_misaligned(in_op, bus.exAluResult[1:0]);
  assign accept      = bus.exValid & ex_ready;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  load_align u_load_align (
    .word     (bus.memRData),
    .byte_sel (lo_q),
    .sign_ext (op_q == MEM_LB),
    .data     (load_byte)
  );

  // State register; reset drops memReq immediately since memReq decodes state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: REQ only for aligned memory ops; ack beats timeout in the same cycle.
  always_comb begin
    state_d       = state_q;
    accept_target = ((in_op == MEM_NONE) || in_misal) ? ST_OUT : ST_REQ;
    case (state_q)
      ST_IDLE: if (accept) state_d = accept_target;
      ST_REQ:  if (bus.memAck || timeout_hit) state_d = ST_OUT;
      ST_OUT: begin
        if (bus.wbReady) state_d = accept ? accept_target : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs plus the registered request and result fields.
  always_comb begin
    ex_ready          = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.wbReady);
    bus.exReady       = ex_ready;
    bus.memReq        = (state_q == ST_REQ);
    bus.memWe         = (state_q == ST_REQ) && is_store_op(op_q);
    bus.memWordAddr   = waddr_q;
    bus.memWData      = wdata_q;
    bus.memByteEn     = be_q;
    bus.wbValid       = (state_q == ST_OUT);
    bus.wbRegDest     = rd_q;
    bus.wbData        = wb_data_q;
    bus.wbWriteEnable = wb_we_q;
    bus.wbErr         = wb_err_q;
  end

  // Datapath: capture the op on acceptance, the result on ack or timeout.
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    waddr_d   = waddr_q;
    lo_d      = lo_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_err_d  = wb_err_q;
    if (accept) begin
      op_d    = in_op;
      rd_d    = bus.exRegDest;
      waddr_d = bus.exAluResult[31:2];
      lo_d    = bus.exAluResult[1:0];
      cnt_d   = '0;
      wdata_d = (in_op == MEM_SB) ? {4{bus.exStoreData[7:0]}} : bus.exStoreData;
      case (in_op)
        MEM_LW, MEM_SW:  be_d = 4'hF;
        MEM_LB, MEM_LBU, MEM_SB: be_d = 4'b0001 << bus.exAluResult[1:0];
        default:         be_d = '0;
      endcase
      if (in_op == MEM_NONE) begin
        wb_data_d = bus.exAluResult;
        wb_we_d   = (bus.exRegDest != 5'd0);
        wb_err_d  = 1'b0;
      end else if (in_misal) begin
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        wb_err_d  = 1'b1;
      end
    end else if (state_q == ST_REQ) begin
      if (bus.memAck) begin
        if (op_q == MEM_LW)         wb_data_d = bus.memRData;
        else if (is_load_op(op_q))  wb_data_d = load_byte;
        else                        wb_data_d = '0;
        wb_we_d  = is_load_op(op_q) && (rd_q != 5'd0);
        wb_err_d = 1'b0;
      end else if (timeout_hit) begin
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        wb_err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= MEM_NONE;
      rd_q      <= '0;
      waddr_q   <= '0;
      lo_q      <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      waddr_q   <= waddr_d;
      lo_q      <= lo_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_err_q  <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed scenarios plus random ops
// against a transaction-level model of the stage.
module tb_stage_memory;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stage_memory_if bus ();

  stage_memory #(.ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input int op);  return (op == 1) || (op == 2) || (op == 3); endfunction
  function automatic bit m_is_store(input int op); return (op == 4) || (op == 5); endfunction
  function automatic bit m_misal(input int op, input logic [31:0] a);
    return ((op == 1) || (op == 4)) && ((a % 4) != 0);
  endfunction
  function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rdata);
    logic [7:0] b;
    b = 8'((rdata >> (8 * (a % 4))) & 32'hFF);
    if (op == 1) return rdata;
    if (op == 2) return {{24{b[7]}}, b};
    return {24'h0, b};
  endfunction

  // One transaction: present op, answer memory after 'delay' request cycles
  // (0 = never), then hold the result 'stall' cycles before consuming it.
  task automatic run_op(input string nm, input int op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic [4:0] rd, input int delay, input int stall);
    bit mem, timeout, done, def_data;
    int exp_req, k, lat;
    logic [31:0] exp_data, exp_wd;
    logic [3:0]  exp_be;
    logic exp_we, exp_err;
    mem      = (m_is_load(op) || m_is_store(op)) && !m_misal(op, addr);
    timeout  = mem && (delay < 1 || delay > 255);
    exp_req  = mem ? (timeout ? 255 : delay) : 0;
    exp_err  = m_misal(op, addr) || timeout;
    exp_we   = !exp_err && (rd != 0) && (op == 0 || op > 5 || m_is_load(op));
    def_data = !exp_err && (op == 0 || op > 5 || m_is_load(op));
    exp_data = (op == 0 || op > 5) ? addr : m_load(op, addr, rdata);
    exp_be   = (op == 4) ? 4'hF : 4'(1 << (addr % 4));
    exp_wd   = (op == 4) ? sdata : {4{sdata[7:0]}};

    @(negedge clk);
    bus.exValid = 1'b1; bus.exMemOp = 3'(op); bus.exAluResult = addr;
    bus.exStoreData = sdata; bus.exRegDest = rd; bus.wbReady = 1'b0;
    #1;
    checks++; if (bus.exReady !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b want 1", nm, bus.exReady); end
    @(negedge clk);
    bus.exValid = 1'b0; bus.exAluResult = $urandom; bus.exStoreData = $urandom; bus.exRegDest = 5'($urandom);
    k = 0; lat = 1; done = 0;
    for (int it = 0; it < 400; it++) begin
      bus.memAck = 1'b0;
      if (bus.wbValid === 1'b1) begin done = 1; break; end
      if (bus.memReq === 1'b1) begin
        k++;
        if (k == 1) begin
          checks++; if (bus.memWordAddr !== addr[31:2] || bus.memWe !== m_is_store(op)) begin
            errors++; $display("FAIL %s req_addr got %h/%b want %h/%b", nm, bus.memWordAddr, bus.memWe, addr[31:2], m_is_store(op)); end
          if (m_is_store(op)) begin
            checks++; if (bus.memByteEn !== exp_be || bus.memWData !== exp_wd) begin
              errors++; $display("FAIL %s store_lanes got %h/%h want %h/%h", nm, bus.memByteEn, bus.memWData, exp_be, exp_wd); end
          end
        end
        if (k == delay) begin bus.memAck = 1'b1; bus.memRData = rdata; end
        else bus.memRData = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    checks++; if (!done) begin errors++; $display("FAIL %s wb_timeout got no wbValid want wbValid within 400 cycles", nm); end
    checks++; if (k != exp_req) begin errors++; $display("FAIL %s req_cycles got %0d want %0d", nm, k, exp_req); end
    checks++; if (lat != exp_req + 1) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_req + 1); end
    checks++; if (bus.wbErr !== exp_err || bus.wbWriteEnable !== exp_we || bus.wbRegDest !== rd) begin
      errors++; $display("FAIL %s wb_flags got err=%b we=%b rd=%0d want err=%b we=%b rd=%0d",
                         nm, bus.wbErr, bus.wbWriteEnable, bus.wbRegDest, exp_err, exp_we, rd); end
    if (def_data) begin
      checks++; if (bus.wbData !== exp_data) begin errors++; $display("FAIL %s wb_data got %h want %h", nm, bus.wbData, exp_data); end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++; if (bus.wbValid !== 1'b1 || bus.exReady !== 1'b0 || bus.wbErr !== exp_err || (def_data && bus.wbData !== exp_data)) begin
        errors++; $display("FAIL %s hold got v=%b rdy=%b err=%b d=%h want v=1 rdy=0 err=%b d=%h",
                           nm, bus.wbValid, bus.exReady, bus.wbErr, bus.wbData, exp_err, exp_data); end
    end
    bus.wbReady = 1'b1;
    #1;
    checks++; if (bus.exReady !== 1'b1) begin errors++; $display("FAIL %s ready_out got %b want 1", nm, bus.exReady); end
    @(negedge clk);
    bus.wbReady = 1'b0;
    checks++; if (bus.wbValid !== 1'b0 || bus.memReq !== 1'b0) begin
      errors++; $display("FAIL %s back_idle got v=%b req=%b want 0 0", nm, bus.wbValid, bus.memReq); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.exReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.exReady); end
    checks++; if ({bus.memReq, bus.memWe, bus.memWordAddr, bus.memWData, bus.memByteEn, bus.wbValid,
                   bus.wbRegDest, bus.wbData, bus.wbWriteEnable, bus.wbErr} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%b we=%b a=%h wd=%h be=%h v=%b rd=%h d=%h wen=%b err=%b want all 0",
                         bus.memReq, bus.memWe, bus.memWordAddr, bus.memWData, bus.memByteEn, bus.wbValid,
                         bus.wbRegDest, bus.wbData, bus.wbWriteEnable, bus.wbErr); end
    reset = 1'b1;
    // Abandon an outstanding load with an asynchronous reset.
    @(negedge clk);
    bus.exValid = 1'b1; bus.exMemOp = 3'd1; bus.exAluResult = 32'h0000_0400; bus.exRegDest = 5'd9;
    @(negedge clk);
    bus.exValid = 1'b0;
    @(negedge clk);
    checks++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", bus.memReq); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.memReq !== 1'b0 || bus.exReady !== 1'b1) begin
      errors++; $display("FAIL async_reset got req=%b rdy=%b want 0 1", bus.memReq, bus.exReady); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.wbValid !== 1'b0 || bus.memReq !== 1'b0) begin
      errors++; $display("FAIL post_reset got v=%b req=%b want 0 0", bus.wbValid, bus.memReq); end
  endtask

  task automatic test_none;
    run_op("none_1234", 0, 32'h0000_1234, 32'h0, 32'h0, 5'd3, 0, 0);
    run_op("none_rd0", 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 0, 1);
    run_op("none_code7", 7, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd12, 0, 0);
  endtask

  task automatic test_loads;
    run_op("lb_neg", 2, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd5, 3, 1);
    run_op("lbu_pos", 3, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd5, 3, 0);
    run_op("lw", 1, 32'h0000_0100, 32'h0, 32'hCAFE_1234, 5'd31, 1, 2);
    run_op("lb_lane0", 2, 32'h0000_0100, 32'h0, 32'h1234_567F, 5'd0, 2, 0);
  endtask

  task automatic test_stores;
    run_op("sb_203", 5, 32'h0000_0203, 32'h0000_00AB, 32'h0, 5'd7, 2, 0);
    run_op("sw", 4, 32'h0000_0300, 32'h8765_4321, 32'h0, 5'd4, 1, 1);
  endtask

  task automatic test_misaligned;
    run_op("lw_misal", 1, 32'h0000_0102, 32'h0, 32'h0, 5'd6, 1, 0);
    run_op("sw_misal", 4, 32'h0000_0101, 32'h1111_2222, 32'h0, 5'd6, 1, 1);
  endtask

  task automatic test_timeout;
    run_op("lw_timeout", 1, 32'h0000_0400, 32'h0, 32'h5555_AAAA, 5'd8, 0, 0);
    // A late ack with nothing outstanding must be ignored.
    @(negedge clk);
    bus.memAck = 1'b1; bus.memRData = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.memAck = 1'b0;
    checks++; if (bus.wbValid !== 1'b0 || bus.memReq !== 1'b0 || bus.exReady !== 1'b1) begin
      errors++; $display("FAIL late_ack got v=%b req=%b rdy=%b want 0 0 1", bus.wbValid, bus.memReq, bus.exReady); end
    run_op("lb_ack_last", 2, 32'h0000_0401, 32'h0, 32'h0000_9C00, 5'd10, 255, 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [6];
    logic [4:0]  r [6];
    logic [31:0] ax;
    bus.wbReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.wbValid !== 1'b1 || bus.wbData !== a[i-1] || bus.wbWriteEnable !== (r[i-1] != 0)) begin
          errors++; $display("FAIL b2b_%0d got v=%b d=%h we=%b want 1 %h %b", i, bus.wbValid, bus.wbData,
                             bus.wbWriteEnable, a[i-1], (r[i-1] != 0)); end
      end
      a[i] = $urandom; r[i] = 5'($urandom_range(0, 31));
      bus.exValid = 1'b1; bus.exMemOp = 3'd0; bus.exAluResult = a[i]; bus.exRegDest = r[i];
      #1;
      checks++; if (bus.exReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, bus.exReady); end
    end
    @(negedge clk);
    ax = $urandom;
    bus.wbReady = 1'b0; bus.exAluResult = ax; bus.exRegDest = 5'd1;
    #1;
    checks++; if (bus.wbData !== a[5] || bus.exReady !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_enter got d=%h rdy=%b want %h 0", bus.wbData, bus.exReady, a[5]); end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++; if (bus.wbValid !== 1'b1 || bus.wbData !== a[5] || bus.exReady !== 1'b0) begin
        errors++; $display("FAIL b2b_stall_%0d got v=%b d=%h rdy=%b want 1 %h 0", s, bus.wbValid, bus.wbData, bus.exReady, a[5]); end
    end
    bus.wbReady = 1'b1;
    @(negedge clk);
    bus.exValid = 1'b0;
    checks++; if (bus.wbValid !== 1'b1 || bus.wbData !== ax || bus.wbWriteEnable !== 1'b1) begin
      errors++; $display("FAIL b2b_resume got v=%b d=%h we=%b want 1 %h 1", bus.wbValid, bus.wbData, bus.wbWriteEnable, ax); end
    @(negedge clk);
    bus.wbReady = 1'b0;
    checks++; if (bus.wbValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.wbValid); end
  endtask

  task automatic test_random;
    int op;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      op   = int'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      run_op("random", op, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    bus.exValid = 1'b0; bus.exAluResult = '0; bus.exStoreData = '0; bus.exRegDest = '0; bus.exMemOp = '0;
    bus.memAck = 1'b0; bus.memRData = '0; bus.wbReady = 1'b0;
    test_reset();
    test_none();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
